// File: rtl/spike_rate_decoder.sv
// Rate-coded spike train to pixel intensity: counts spikes over a fixed window of
// qualified samples and rescales the count to the full WIDTH-bit pixel range.
module spike_rate_decoder #(
  parameter int WIDTH       = 16,
  parameter int WINDOW_SIZE = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_in,
  input  logic                   spike_valid,
  input  logic                   window_clear,
  output logic [WINDOW_SIZE-1:0] spike_window,
  output logic [$clog2(WINDOW_SIZE+1)-1:0] window_count,
  output logic [WIDTH-1:0]       pixel_estimate,
  output logic                   out_valid,
  output logic                   busy
);

  localparam int CW = $clog2(WINDOW_SIZE+1);
  localparam logic [WIDTH-1:0] MAXV  = '1;
  localparam logic [WIDTH-1:0] SCALE = WIDTH'(MAXV / WINDOW_SIZE);
  localparam logic [CW-1:0]    LAST  = CW'(WINDOW_SIZE-1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t state, next_state;

  logic [CW-1:0]          cnt_p0;
  logic [CW-1:0]          acc_p0;
  logic [WINDOW_SIZE-2:0] shreg_p0;
  logic [WINDOW_SIZE-1:0] full_win;
  logic [CW-1:0]          final_cnt;
  logic                   qual;
  logic                   closing;

  logic [CW-1:0]          count_p1;
  logic [WINDOW_SIZE-1:0] win_p1;
  logic                   vld_p1;

  // Product of count and SCALE never exceeds the pixel range, so plain truncation is exact.
  function automatic logic [WIDTH-1:0] scale_count(input logic [CW-1:0] c);
    logic [WIDTH+CW-1:0] prod;
    prod = (WIDTH+CW)'(c) * (WIDTH+CW)'(SCALE);
    return prod[WIDTH-1:0];
  endfunction

  assign qual      = spike_valid & ~window_clear;
  assign closing   = qual & (cnt_p0 == LAST);
  assign full_win  = {shreg_p0, spike_in};
  assign final_cnt = acc_p0 + CW'(spike_in);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (qual) next_state = ACCUM;
      ACCUM:   if (window_clear || closing) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ACCUM);
  end

  // Stage 0: sample accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0   <= '0;
      acc_p0   <= '0;
      shreg_p0 <= '0;
    end else if (window_clear || closing) begin
      cnt_p0   <= '0;
      acc_p0   <= '0;
      shreg_p0 <= '0;
    end else if (spike_valid) begin
      cnt_p0   <= cnt_p0 + 1'b1;
      acc_p0   <= final_cnt;
      shreg_p0 <= full_win[WINDOW_SIZE-2:0];
    end
  end

  // Stage 1: hold the completed window's count and bitmap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_p1 <= '0;
      win_p1   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= closing;
      if (closing) begin
        count_p1 <= final_cnt;
        win_p1   <= full_win;
      end
    end
  end

  // Stage 2: scaled estimate and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_estimate <= '0;
      window_count   <= '0;
      spike_window   <= '0;
      out_valid      <= 1'b0;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        pixel_estimate <= scale_count(count_p1);
        window_count   <= count_p1;
        spike_window   <= win_p1;
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder (WIDTH=16, WINDOW_SIZE=5).
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spike_in = 1'b0;
  logic        spike_valid = 1'b0;
  logic        window_clear = 1'b0;
  logic [4:0]  spike_window;
  logic [2:0]  window_count;
  logic [15:0] pixel_estimate;
  logic        out_valid;
  logic        busy;

  spike_rate_decoder #(.WIDTH(16), .WINDOW_SIZE(5)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .spike_valid(spike_valid),
    .window_clear(window_clear), .spike_window(spike_window),
    .window_count(window_count), .pixel_estimate(pixel_estimate),
    .out_valid(out_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cnt;
    int         pix;
    logic [4:0] win;
    int         due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  // model state
  int         m_cnt = 0;
  int         m_acc = 0;
  logic [4:0] m_win = '0;
  int         last_cnt = 0;
  int         last_pix = 0;
  logic [4:0] last_win = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      check("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("window_count", 32'(window_count), e.cnt);
        check("pixel_estimate", 32'(pixel_estimate), e.pix);
        check("spike_window", 32'(spike_window), 32'(e.win));
        check("latency", cyc, e.due);
        last_cnt = e.cnt;
        last_pix = e.pix;
        last_win = e.win;
      end
    end
  end

  // One clock of stimulus; the model advances on the same edge the DUT does.
  task automatic step(input logic v, input logic s, input logic c);
    spike_valid  = v;
    spike_in     = s;
    window_clear = c;
    @(posedge clk);
    #1;
    if (c) begin
      m_cnt = 0; m_acc = 0; m_win = '0;
    end else if (v) begin
      m_win = {m_win[3:0], s};
      m_acc += int'(s);
      m_cnt++;
      if (m_cnt == 5) begin
        exp_t e;
        e.cnt = m_acc;
        e.pix = m_acc * 13107;
        e.win = m_win;
        e.due = cyc + 1;
        sb.push_back(e);
        m_cnt = 0; m_acc = 0; m_win = '0;
      end
    end
  endtask

  task automatic window5(input logic [4:0] bits);
    for (int i = 4; i >= 0; i--) step(1'b1, bits[i], 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    spike_valid = 1'b0; spike_in = 1'b0; window_clear = 1'b0;
    rst = 1'b1;
    sb.delete();
    m_cnt = 0; m_acc = 0; m_win = '0;
    last_cnt = 0; last_pix = 0; last_win = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_count"}, 32'(window_count), 0);
    check({tag, "_pixel"}, 32'(pixel_estimate), 0);
    check({tag, "_window"}, 32'(spike_window), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int p0;
    do_reset();
    check_zero("reset");
    check("reset_valid", 32'(out_valid), 0);

    // all ones
    step(1'b1, 1'b1, 1'b0);
    check("busy_first", 32'(busy), 1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    check("busy_after_close", 32'(busy), 0);
    idle(3);

    // 1,0,1,1,0 with gaps carrying spikes that must be ignored
    begin
      logic [4:0] pat;
      pat = 5'b10110;
      p0 = pulses;
      for (int i = 4; i >= 0; i--) begin
        step(1'b1, pat[i], 1'b0);
        if (i != 0) begin
          step(1'b0, 1'b1, 1'b0);
          step(1'b0, 1'b1, 1'b0);
        end
      end
      idle(3);
      check("gap_pulses", pulses - p0, 1);
    end

    // back-to-back windows
    p0 = pulses;
    window5(5'b11111);
    window5(5'b00000);
    window5(5'b10000);
    idle(3);
    check("b2b_pulses", pulses - p0, 3);

    // clear on third sample, then a full window
    p0 = pulses;
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("busy_after_clear", 32'(busy), 0);
    window5(5'b11111);
    idle(3);
    check("clear_pulses", pulses - p0, 1);

    // clear coinciding with the closing sample
    p0 = pulses;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    idle(3);
    check("clear_close_pulses", pulses - p0, 0);
    check("hold_count", 32'(window_count), last_cnt);
    check("hold_pixel", 32'(pixel_estimate), last_pix);
    check("hold_window", 32'(spike_window), 32'(last_win));

    // clear one cycle after the closing sample
    p0 = pulses;
    window5(5'b01101);
    step(1'b0, 1'b0, 1'b1);
    idle(3);
    check("clear_after_pulses", pulses - p0, 1);

    // reset mid-window
    p0 = pulses;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    do_reset();
    check_zero("rst_mid");
    // reset during stage 2
    window5(5'b11011);
    do_reset();
    idle(3);
    check_zero("rst_s2");
    check("rst_pulses", pulses - p0, 0);
    p0 = pulses;
    window5(5'b11001);
    idle(3);
    check("post_rst_pulses", pulses - p0, 1);

    check("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
